// File: rtl/snn_session_sequencer.sv
// snn_session_sequencer: job FIFO feeding a per-image stage sequencer
// for the pre-core / core / post-core SNN datapath.
module snn_session_sequencer #(
   parameter int LABEL_W   = 8,
   parameter int JOB_DEPTH = 4,
   parameter int TIMEOUT   = 65535,
   parameter int TO_W      = 16,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [1:0]         job_mode,
   input  logic [LABEL_W-1:0] job_label,
   input  logic               abort,
   input  logic               clear_stats,
   input  logic               valid_buffering,
   input  logic               valid_rfing,
   input  logic               valid_maxing,
   input  logic               done_core_img,
   input  logic               valid_deciding,
   input  logic [LABEL_W-1:0] decided_label,
   output logic               buffering,
   output logic               rfing,
   output logic               maxing,
   output logic               coring,
   output logic               start_core_img,
   output logic               deciding,
   output logic [1:0]         mode_cur,
   output logic               busy,
   output logic               res_valid,
   output logic [LABEL_W-1:0] res_label,
   output logic [1:0]         res_mode,
   output logic [1:0]         res_status,
   output logic               res_match,
   output logic [CNT_W-1:0]   image_count,
   output logic [CNT_W-1:0]   correct_count
);

   localparam int PW = $clog2(JOB_DEPTH);
   localparam int JW = LABEL_W + 2;
   localparam bit TO_EN = (TIMEOUT != 0);
   localparam logic [TO_W-1:0] TO_LAST =
      TO_W'(TO_EN ? TIMEOUT - 1 : 0);
   localparam logic [PW:0] DEPTH = (PW+1)'(JOB_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_BUF, S_RF, S_MAX, S_CORE, S_DEC, S_RES
   } state_t;

   state_t state, nxt, stage_nxt;

   logic [JW-1:0]      mem [JOB_DEPTH];
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [PW:0]        count;
   logic               avail, push, pop;
   logic [1:0]         head_mode, mode_q, nstat;
   logic [LABEL_W-1:0] head_label, label_q;
   logic [TO_W-1:0]    tcnt;
   logic               done_cur, tmo, core_first, ok;

   assign job_ready  = (count != DEPTH);
   assign push       = job_valid && job_ready;
   assign pop        = (state == S_IDLE) && avail;
   assign head_mode  = mem[rd_ptr][JW-1 -: 2];
   assign head_label = mem[rd_ptr][LABEL_W-1:0];
   assign tmo        = TO_EN && (tcnt == TO_LAST);
   assign ok         = (nstat == 2'b00);
   assign mode_cur   = mode_q;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {job_mode, job_label};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         avail  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: ;
         endcase
         // FSM sees occupancy one cycle late; a popped entry cannot be
         // re-seen because IDLE is always at least two cycles away.
         avail <= (count != '0);
      end
   end

   always_comb begin
      done_cur  = 1'b0;
      stage_nxt = S_RES;
      unique case (state)
         S_BUF:  begin done_cur = valid_buffering; stage_nxt = S_RF;   end
         S_RF:   begin done_cur = valid_rfing;     stage_nxt = S_MAX;  end
         S_MAX:  begin done_cur = valid_maxing;    stage_nxt = S_CORE; end
         S_CORE: begin done_cur = done_core_img;   stage_nxt = S_DEC;  end
         S_DEC:  begin done_cur = valid_deciding;  stage_nxt = S_RES;  end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt   = state;
      nstat = 2'b00;
      unique case (state)
         S_IDLE: begin
            if (avail) begin
               if (head_mode == 2'b11) begin
                  nxt   = S_RES;
                  nstat = 2'b11;
               end else begin
                  nxt = S_BUF;
               end
            end
         end
         S_BUF, S_RF, S_MAX, S_CORE, S_DEC: begin
            if (abort) begin
               nxt   = S_RES;
               nstat = 2'b10;
            end else if (done_cur) begin
               nxt = stage_nxt;
            end else if (tmo) begin
               nxt   = S_RES;
               nstat = 2'b01;
            end
         end
         S_RES:   nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   always_comb begin
      buffering      = 1'b0;
      rfing          = 1'b0;
      maxing         = 1'b0;
      coring         = 1'b0;
      deciding       = 1'b0;
      unique case (state)
         S_BUF:   buffering = 1'b1;
         S_RF:    rfing     = 1'b1;
         S_MAX:   maxing    = 1'b1;
         S_CORE:  coring    = 1'b1;
         S_DEC:   deciding  = 1'b1;
         default: ;
      endcase
      busy           = (state != S_IDLE);
      res_valid      = (state == S_RES);
      start_core_img = (state == S_CORE) && core_first;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt       <= '0;
         core_first <= 1'b0;
         mode_q     <= '0;
         label_q    <= '0;
         res_label  <= '0;
         res_mode   <= '0;
         res_status <= '0;
         res_match  <= 1'b0;
      end else begin
         tcnt       <= (nxt != state) ? '0 : tcnt + TO_W'(1);
         core_first <= (nxt == S_CORE) && (state != S_CORE);
         if (pop) begin
            mode_q  <= head_mode;
            label_q <= head_label;
         end
         if (nxt == S_RES) begin
            res_status <= nstat;
            res_mode   <= (state == S_IDLE) ? head_mode : mode_q;
            res_label  <= ok ? decided_label : '0;
            res_match  <= ok && (mode_q == 2'b01) &&
                          (decided_label == label_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear_stats) begin
         image_count   <= '0;
         correct_count <= '0;
      end else if (state == S_RES) begin
         if (res_status == 2'b00 && image_count != CNT_MAX)
            image_count <= image_count + CNT_W'(1);
         if (res_match && correct_count != CNT_MAX)
            correct_count <= correct_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_snn_session_sequencer.sv
// Directed bench for snn_session_sequencer: job table plus
// hand-written FIFO-full, reset-mid-image and saturation sequences.
module tb_snn_session_sequencer;

   localparam int LW   = 8;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          job_valid = 1'b0;
   logic          job_ready;
   logic [1:0]    job_mode = '0;
   logic [LW-1:0] job_label = '0;
   logic          abort = 1'b0;
   logic          clear_stats = 1'b0;
   logic          valid_buffering = 1'b0;
   logic          valid_rfing = 1'b0;
   logic          valid_maxing = 1'b0;
   logic          done_core_img = 1'b0;
   logic          valid_deciding = 1'b0;
   logic [LW-1:0] decided_label = '0;
   logic          buffering, rfing, maxing, coring;
   logic          start_core_img, deciding, busy, res_valid;
   logic [1:0]    mode_cur, res_mode, res_status;
   logic [LW-1:0] res_label;
   logic          res_match;
   logic [CW-1:0] image_count, correct_count;

   int total = 0;
   int bad   = 0;
   int m_img = 0;
   int m_cor = 0;

   typedef struct {
      logic [1:0]    mode;
      logic [LW-1:0] label;
      logic [LW-1:0] dlab;
      int            kind;
      logic          clr;
      logic [1:0]    st;
      logic [LW-1:0] rlab;
      logic          match;
      int            res_at;
      int            ncore;
      int            nstart;
      int            nlvl;
   } vec_t;

   vec_t tbl[8];
   vec_t sat_v, clr_v;

   snn_session_sequencer #(
      .LABEL_W(LW), .JOB_DEPTH(4), .TIMEOUT(10),
      .TO_W(16), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_mode(job_mode), .job_label(job_label),
      .abort(abort), .clear_stats(clear_stats),
      .valid_buffering(valid_buffering),
      .valid_rfing(valid_rfing),
      .valid_maxing(valid_maxing),
      .done_core_img(done_core_img),
      .valid_deciding(valid_deciding),
      .decided_label(decided_label),
      .buffering(buffering), .rfing(rfing),
      .maxing(maxing), .coring(coring),
      .start_core_img(start_core_img),
      .deciding(deciding), .mode_cur(mode_cur),
      .busy(busy), .res_valid(res_valid),
      .res_label(res_label), .res_mode(res_mode),
      .res_status(res_status), .res_match(res_match),
      .image_count(image_count),
      .correct_count(correct_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model(input logic [1:0] st, input logic m,
                        input logic clr);
      if (clr) begin
         m_img = 0;
         m_cor = 0;
      end else begin
         if (st == 2'b00 && m_img < CMAX) m_img++;
         if (m && m_cor < CMAX) m_cor++;
      end
   endtask

   task automatic idle_inputs();
      valid_buffering = 1'b0;
      valid_rfing     = 1'b0;
      valid_maxing    = 1'b0;
      done_core_img   = 1'b0;
      valid_deciding  = 1'b0;
      abort           = 1'b0;
      clear_stats     = 1'b0;
   endtask

   // kind: 0 immediate dones, 1 withhold core done, 2 abort in MAX
   task automatic drive_dones(input logic [LW-1:0] dl, input int kind);
      valid_buffering = buffering;
      valid_rfing     = rfing;
      valid_maxing    = maxing;
      done_core_img   = coring && (kind != 1);
      valid_deciding  = deciding;
      decided_label   = dl;
      abort           = maxing && (kind == 2);
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_img_cnt"}, 32'(image_count), m_img);
      chk({tag, "_cor_cnt"}, 32'(correct_count), m_cor);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int  first_buf = -1;
      int  res_at = -1;
      int  n_core = 0;
      int  n_start = 0;
      int  n_lvl = 0;
      bit  seen = 1'b0;
      @(negedge clk);
      chk({tag, "_push_ready"}, job_ready, 1);
      job_valid = 1'b1;
      job_mode  = v.mode;
      job_label = v.label;
      @(posedge clk);
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         job_valid = 1'b0;
         if (buffering && first_buf < 0) begin
            first_buf = i;
            chk({tag, "_mode_cur"}, mode_cur, v.mode);
         end
         n_lvl   += int'(buffering) + int'(rfing) + int'(maxing)
                  + int'(coring) + int'(deciding);
         n_core  += int'(coring);
         n_start += int'(start_core_img);
         if (res_valid) begin
            seen   = 1'b1;
            res_at = i;
            chk({tag, "_status"}, res_status, v.st);
            chk({tag, "_label"}, res_label, v.rlab);
            chk({tag, "_match"}, res_match, v.match);
            chk({tag, "_rmode"}, res_mode, v.mode);
            clear_stats = v.clr;
         end
         drive_dones(v.dlab, v.kind);
      end
      chk({tag, "_res_seen"}, seen, 1);
      chk({tag, "_res_at"}, res_at, v.res_at);
      chk({tag, "_first_buf"}, first_buf,
          (v.mode == 2'b11) ? -1 : 2);
      chk({tag, "_n_core"}, n_core, v.ncore);
      chk({tag, "_n_start"}, n_start, v.nstart);
      chk({tag, "_n_lvl"}, n_lvl, v.nlvl);
      @(negedge clk);
      idle_inputs();
      model(v.st, v.match, v.clr);
      chk_counts(tag);
      chk({tag, "_idle"}, {busy, res_valid}, 0);
   endtask

   task automatic serve(input int n, input logic [LW-1:0] base);
      int idx = 0;
      for (int c = 0; c < 200 && idx < n; c++) begin
         @(negedge clk);
         if (res_valid) begin
            chk("fifo_status", res_status, 0);
            chk("fifo_order", res_label, 8'(base + idx));
            chk("fifo_match", res_match, 1);
            model(2'b00, 1'b1, 1'b0);
            idx++;
         end
         drive_dones(8'(base + idx), 0);
      end
      chk("fifo_served", idx, n);
      @(negedge clk);
      idle_inputs();
      chk_counts("fifo");
   endtask

   initial begin
      bit got;

      tbl[0] = '{2'd1, 8'd5,   8'd5,   0, 1'b0, 2'd0, 8'd5,
                 1'b1, 7, 1, 1, 5};
      tbl[1] = '{2'd1, 8'd3,   8'd7,   0, 1'b0, 2'd0, 8'd7,
                 1'b0, 7, 1, 1, 5};
      tbl[2] = '{2'd0, 8'd9,   8'd9,   0, 1'b0, 2'd0, 8'd9,
                 1'b0, 7, 1, 1, 5};
      tbl[3] = '{2'd2, 8'd0,   8'h42,  0, 1'b0, 2'd0, 8'h42,
                 1'b0, 7, 1, 1, 5};
      tbl[4] = '{2'd1, 8'd5,   8'd5,   1, 1'b0, 2'd1, 8'd0,
                 1'b0, 15, 10, 1, 13};
      tbl[5] = '{2'd1, 8'd6,   8'd6,   2, 1'b0, 2'd2, 8'd0,
                 1'b0, 5, 0, 0, 3};
      tbl[6] = '{2'd3, 8'd1,   8'd1,   0, 1'b0, 2'd3, 8'd0,
                 1'b0, 2, 0, 0, 0};
      tbl[7] = '{2'd1, 8'hFF,  8'hFF,  0, 1'b0, 2'd0, 8'hFF,
                 1'b1, 7, 1, 1, 5};
      sat_v  = '{2'd1, 8'h33,  8'h33,  0, 1'b0, 2'd0, 8'h33,
                 1'b1, 7, 1, 1, 5};
      clr_v  = '{2'd1, 8'h44,  8'h44,  0, 1'b1, 2'd0, 8'h44,
                 1'b1, 7, 1, 1, 5};

      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_outs", {buffering, rfing, maxing, coring,
          start_core_img, deciding, busy, res_valid, res_match,
          mode_cur, res_mode, res_status}, 0);
      chk("rst_label", res_label, 0);
      chk("rst_counts", {image_count, correct_count}, 0);
      chk("rst_ready", job_ready, 1);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst", {job_ready, busy}, 2'b10);

      for (int i = 0; i < 8; i++)
         run_vec(tbl[i], $sformatf("v%0d", i));

      // fill the FIFO behind a job stalled in BUF
      @(negedge clk);
      job_valid = 1'b1;
      job_mode  = 2'd1;
      job_label = 8'h10;
      @(negedge clk);
      job_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         if (buffering) got = 1'b1;
         else @(negedge clk);
      end
      chk("a_in_buf", got, 1);
      for (int k = 0; k < 4; k++) begin
         chk("fill_ready", job_ready, 1);
         job_valid = 1'b1;
         job_mode  = 2'd1;
         job_label = 8'(32 + k);
         @(negedge clk);
      end
      job_label = 8'h24;
      chk("full_ready", job_ready, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("a_res_valid", res_valid, 1);
      chk("a_status", res_status, 2);
      chk("a_label", res_label, 0);
      model(2'd2, 1'b0, 1'b0);
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         if (job_ready) got = 1'b1;
         @(negedge clk);
      end
      job_valid = 1'b0;
      chk("fifth_accepted", got, 1);
      serve(5, 8'h20);

      // reset while the core is running
      @(negedge clk);
      job_valid = 1'b1;
      job_mode  = 2'd1;
      job_label = 8'd5;
      @(negedge clk);
      job_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         if (coring) got = 1'b1;
         else begin
            drive_dones(8'd5, 0);
            @(negedge clk);
         end
      end
      chk("mid_core", got, 1);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_outs", {busy, coring, res_valid, res_status}, 0);
      chk("mid_rst_counts", {image_count, correct_count}, 0);
      chk("mid_rst_ready", job_ready, 1);
      got = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (res_valid || busy) got = 1'b1;
      end
      chk("mid_rst_no_result", got, 0);
      m_img = 0;
      m_cor = 0;

      for (int r = 0; r < 16; r++)
         run_vec(sat_v, $sformatf("sat%0d", r));
      chk("img_sat", image_count, CMAX);
      chk("cor_sat", correct_count, CMAX);
      run_vec(clr_v, "clr");
      chk("clr_zero", {image_count, correct_count}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
